// File: rtl/cpu_pkg.sv
// cpu_pkg: shared stack FSM states, operation codes and default data width
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} stack_state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_PEEK} stack_op_t;
endpackage

// File: rtl/stack_unit_if.sv
// stack_unit_if: CU <-> stack request/response bundle; peek signals exist only with STACK_PEEK_EN
interface stack_unit_if import cpu_pkg::*; #(parameter int DATA_W = DATA_W_DEF, parameter int DEPTH = 64);
  localparam int SW = $clog2(DEPTH) + 1;
  logic push;
  logic pop;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] pop_out;
  logic push_done;
  logic pop_done;
  logic [SW-1:0] sp;
  logic full;
  logic empty;
  logic err;
`ifdef STACK_PEEK_EN
  logic peek;
  logic peek_done;
  modport master(output push, pop, peek, push_data,
                 input pop_out, push_done, pop_done, peek_done, sp, full, empty, err);
  modport slave(input push, pop, peek, push_data,
                output pop_out, push_done, pop_done, peek_done, sp, full, empty, err);
`else
  modport master(output push, pop, push_data,
                 input pop_out, push_done, pop_done, sp, full, empty, err);
  modport slave(input push, pop, push_data,
                output pop_out, push_done, pop_done, sp, full, empty, err);
`endif
endinterface

// File: rtl/stack_unit_ram.sv
// stack_ram: single-port storage, synchronous write, registered read, no reset
module stack_ram #(parameter int DATA_W = 16, parameter int DEPTH = 64) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/stack_unit.sv
// stack_unit: one-request-at-a-time LIFO with push/pop (and peek when STACK_PEEK_EN) handshake
module stack_unit import cpu_pkg::*; #(parameter int DATA_W = DATA_W_DEF, parameter int DEPTH = 64) (
  input logic clk,
  input logic rst,
  stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);
  stack_state_t state;
  stack_op_t op;
  logic rej;
  logic [AW:0] sp;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata;
  logic [AW-1:0] addr;
  logic we;
  logic full;
  logic empty;
  logic peek_req;
`ifdef STACK_PEEK_EN
  assign peek_req = bus.peek;
`else
  assign peek_req = 1'b0;
`endif
  assign full = sp == SP_MAX;
  assign empty = sp == '0;
  assign bus.sp = sp;
  assign bus.full = full;
  assign bus.empty = empty;
  assign we = state == WRITE && !full;
  // Reads target the top entry (sp-1); writes target the first free slot (sp).
  assign addr = state == WRITE ? sp[AW-1:0] : AW'(sp - 1'b1);
  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .addr(addr), .wdata(data_q), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp <= '0;
      bus.pop_out <= '0;
      bus.push_done <= 1'b0;
      bus.pop_done <= 1'b0;
      bus.err <= 1'b0;
`ifdef STACK_PEEK_EN
      bus.peek_done <= 1'b0;
`endif
    end else begin
      bus.push_done <= 1'b0;
      bus.pop_done <= 1'b0;
      bus.err <= 1'b0;
`ifdef STACK_PEEK_EN
      bus.peek_done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          op <= bus.push ? OP_PUSH : bus.pop ? OP_POP : OP_PEEK;
          data_q <= bus.push_data;
          state <= bus.push ? WRITE : (bus.pop || peek_req) ? READ : IDLE;
        end
        WRITE: begin
          rej <= full;
          sp <= full ? sp : sp + 1'b1;
          state <= DONE;
        end
        READ: begin
          rej <= empty;
          sp <= (empty || op != OP_POP) ? sp : sp - 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.push_done <= op == OP_PUSH;
          bus.pop_done <= op == OP_POP;
`ifdef STACK_PEEK_EN
          bus.peek_done <= op == OP_PEEK;
`endif
          bus.err <= rej;
          bus.pop_out <= op == OP_PUSH ? bus.pop_out : rej ? '0 : rdata;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
